// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   ALU_DATA_W : operand/result width of the shared ALU
//   ALU_CODE_W : width of the ALU operation code
//   port_id_t  : requester index (0 = instruction datapath, 1 = address/flag unit)
//   ALU_*      : ALU operation codes
package alu_arb_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_CODE_W = 3;

    typedef logic port_id_t;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b100;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR = 3'b101;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU.
//   a, b  : operands
//   code  : operation code (ALU_* in alu_arb_pkg); unknown codes pass a through
//   out   : result
//   carry : carry out (ADD) / borrow (SUB), 0 otherwise
//   zero  : out == 0
module alu
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CODE_W = ALU_CODE_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] out,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (code)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = {1'b0, a};
        endcase
    end

    assign out   = wide[DATA_W-1:0];
    assign carry = wide[DATA_W];
    assign zero  = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_arb_grant.sv
// Eligibility and single-grant selection for the two ALU requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req0/1_valid      : request present
//   busy0/1           : port has an op in flight or an unconsumed result
//   gnt0/1            : grant (at most one set); forced low during reset
// Macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins a tie (no last_grant state).
// Default: round-robin on ties using last_grant (reset to port 1).
module alu_arb_grant
    import alu_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic busy0,
    input  logic busy1,
    output logic gnt0,
    output logic gnt1
);

    logic elig0;
    logic elig1;

    assign elig0 = rst_n && req0_valid && !busy0;
    assign elig1 = rst_n && req1_valid && !busy1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
    end
`else
    port_id_t last_grant;

    always_comb begin
        gnt0 = elig0;
        gnt1 = elig1;
        if (elig0 && elig1) begin
            gnt0 = (last_grant == 1'b1);
            gnt1 = (last_grant == 1'b0);
        end
    end

    // Records every grant so a tie goes to whichever port was served less recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between port 0 (instruction datapath) and port 1
// (address/flag unit). A granted request is registered into the operand
// stage, the ALU result is captured into that port's result register on the
// following edge and held until the requester consumes it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqX_valid/ready    : request handshake (ready = grant this cycle)
//   reqX_a/b/code       : operands and ALU operation code
//   rspX_valid/ready    : result handshake
//   rspX_out/carry/zero : held ALU result and flags
// Tie-break policy selected in alu_arb_grant (macro ALU_ARB_FIXED_PRIO_EN).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CODE_W = ALU_CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CODE_W-1:0] req0_code,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CODE_W-1:0] req1_code,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_out,
    output logic              rsp0_carry,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_out,
    output logic              rsp1_carry,
    output logic              rsp1_zero
);

    logic              op_vld;
    port_id_t          op_port;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CODE_W-1:0] op_code;

    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              alu_zero;

    logic busy0, busy1;
    logic gnt0, gnt1;

    // A result being consumed this cycle frees the port, letting a new
    // request in on the same edge.
    assign busy0 = (op_vld && op_port == 1'b0) || (rsp0_valid && !rsp0_ready);
    assign busy1 = (op_vld && op_port == 1'b1) || (rsp1_valid && !rsp1_ready);

    alu_arb_grant u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .busy0      (busy0),
        .busy1      (busy1),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    alu #(
        .DATA_W (DATA_W),
        .CODE_W (CODE_W)
    ) u_alu (
        .a     (op_a),
        .b     (op_b),
        .code  (op_code),
        .out   (alu_out),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld  <= 1'b0;
            op_port <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
        end else begin
            op_vld <= gnt0 || gnt1;
            if (gnt0) begin
                op_port <= 1'b0;
                op_a    <= req0_a;
                op_b    <= req0_b;
                op_code <= req0_code;
            end else if (gnt1) begin
                op_port <= 1'b1;
                op_a    <= req1_a;
                op_b    <= req1_b;
                op_code <= req1_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_carry <= 1'b0;
            rsp0_zero  <= 1'b0;
        end else if (op_vld && op_port == 1'b0) begin
            rsp0_valid <= 1'b1;
            rsp0_out   <= alu_out;
            rsp0_carry <= alu_carry;
            rsp0_zero  <= alu_zero;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_carry <= 1'b0;
            rsp1_zero  <= 1'b0;
        end else if (op_vld && op_port == 1'b1) begin
            rsp1_valid <= 1'b1;
            rsp1_out   <= alu_out;
            rsp1_carry <= alu_carry;
            rsp1_zero  <= alu_zero;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (default round-robin build).
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_code, req1_code;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_out, rsp1_out;
    logic       rsp0_carry, rsp1_carry;
    logic       rsp0_zero, rsp1_zero;

    int unsigned total;
    int unsigned bad;

    alu_arbiter #(.DATA_W(8), .CODE_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_code  (req0_code),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_code  (req1_code),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_out   (rsp0_out),
        .rsp0_carry (rsp0_carry),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_out   (rsp1_out),
        .rsp1_carry (rsp1_carry),
        .rsp1_zero  (rsp1_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_code = 3'b001;
        req1_a = '0; req1_b = '0; req1_code = 3'b001;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state: ready held low even with valid asserted
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_out",   rsp0_out,   0);
        check("rst_rsp1_out",   rsp1_out,   0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Port 0: 2 + 5
        req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd5;
        #1;
        check("p0_add_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("p0_add_lat_valid", rsp0_valid, 0);
        tick();
        check("p0_add_valid", rsp0_valid, 1);
        check("p0_add_out",   rsp0_out,   7);
        check("p0_add_carry", rsp0_carry, 0);
        check("p0_add_zero",  rsp0_zero,  0);
        tick();
        check("p0_consumed", rsp0_valid, 0);

        // Port 1: 200 + 100, then 128 + 128
        req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd100;
        #1;
        check("p1_add_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("p1_add_out",   rsp1_out,   44);
        check("p1_add_carry", rsp1_carry, 1);
        check("p1_add_zero",  rsp1_zero,  0);
        req1_valid = 1'b1; req1_a = 8'd128; req1_b = 8'd128;
        #1;
        check("p1_bypass_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("p1_ovf_valid", rsp1_valid, 1);
        check("p1_ovf_out",   rsp1_out,   0);
        check("p1_ovf_carry", rsp1_carry, 1);
        check("p1_ovf_zero",  rsp1_zero,  1);
        tick(); tick();

        // Both streaming: grants alternate starting with port 0
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_a = 8'(i); req0_b = 8'd100;
            req1_valid = 1'b1; req1_a = 8'(i); req1_b = 8'd50;
            #1;
            check("stream_gnt0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("stream_gnt1", req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i >= 2 && i % 2 == 0) check("stream_rsp0", rsp0_out, i - 2 + 100);
            if (i >= 3 && i % 2 == 1) check("stream_rsp1", rsp1_out, i - 2 + 50);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();

        // Port 0 result held while port 1 keeps being served
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
        #1;
        check("hold_first_ready", req0_ready, 1);
        tick();
        req0_a = 8'd9; req0_b = 8'd9;
        #1;
        check("hold_inflight_ready", req0_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            req1_valid = 1'b1; req1_a = 8'(i); req1_b = 8'd1;
            #1;
            check("hold_rsp0_valid", rsp0_valid, 1);
            check("hold_rsp0_out",   rsp0_out,   7);
            check("hold_req0_ready", req0_ready, 0);
            check("hold_req1_ready", req1_ready, (i % 2 == 0) ? 1 : 0);
            tick();
        end
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        #1;
        check("bypass_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("bypass_cleared", rsp0_valid, 0);
        tick();
        check("bypass_valid", rsp0_valid, 1);
        check("bypass_out",   rsp0_out,   18);
        tick(); tick(); tick();

        // Reset one cycle after accept discards the operation
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
        #1;
        check("rr_accept", req0_ready, 1);
        tick();
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("rr_in_rst_ready0", req0_ready, 0);
        check("rr_in_rst_ready1", req1_ready, 0);
        check("rr_in_rst_valid",  rsp0_valid, 0);
        tick();
        check("rr_no_rsp", rsp0_valid, 0);
        rst_n = 1'b1;
        req0_a = 8'd20; req0_b = 8'd22;
        #1;
        check("rr_tie_gnt0", req0_ready, 1);
        check("rr_tie_gnt1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_post_lat", rsp0_valid, 0);
        tick();
        check("rr_post_valid", rsp0_valid, 1);
        check("rr_post_out",   rsp0_out,   42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
